fetch_inst_buffer: RTL and testbench
====================================

// Module: fetch_inst_buffer
// PURPOSE
//   Instruction buffer between fetch and dual-issue decode. Each cycle it accepts one
//   fetch group of up to 4 instructions, tagged with the branch predictor's valid mask,
//   jump flags and predicted next PC. It compacts the valid slots in order into a
//   circular FIFO and presents the two oldest entries to decode.
// PARAMETERS
//   DEPTH     16  entry count; power of two, >= 8
//   IDX_W     4   log2(DEPTH)
// PORTS
//   clk         in   1    clock; all state updates on rising edge
//   reset       in   1    asynchronous, active-high reset
//   flush       in   1    pipeline redirect (exe / bpu / ID flush OR'd by parent); drops all
//   in_valid    in   1    fetch group present
//   in_ready    out  1    buffer can take a full group this cycle
//   in_pc       in   32   fetch PC; group base = {in_pc[31:4],4'b0}
//   in_inst     in   128  slot k instruction in bits [32k+31:32k]
//   in_mask     in   4    per-slot valid (predictor pc_valid)
//   in_jump     in   4    per-slot predicted-taken (predictor pc_is_jump); at most one set
//   in_target   in   32   predicted next PC of the group
//   out_valid   out  2    [0]: lane0 holds an entry; [1]: lane1 holds an entry
//   out_ready   in   2    decode consumes lane0 / lane1
//   out_pc0/1   out  32   PC of oldest / second-oldest entry
//   out_inst0/1 out  32   instruction word
//   out_jump0/1 out  1    entry predicted taken
//   out_tgt0/1  out  32   predicted target (meaningful only when out_jumpN=1)
//   count       out  IDX_W+1  current occupancy
// BEHAVIOUR
//   - Storage: DEPTH x {pc, inst, jump, target}. Pointers head, tail (IDX_W bits,
//     natural wrap) and count (0..DEPTH). Storage is not reset.
//   - Async reset: head=tail=count=0 immediately. out_valid=00, in_ready=1 while
//     reset is deasserted and count=0.
//   - in_ready = (count <= DEPTH-4) && !flush. It uses the current count only; a
//     same-cycle dequeue does not raise it.
//   - Enqueue fires on in_valid && in_ready. Slots with in_mask[k]=1 are written in
//     ascending k to tail, tail+1, ...
//     pc = base + 4k; jump = in_jump[k]; target = in_target.
//     n_enq = popcount(in_mask), 0..4. Mask 0000 is accepted and writes nothing.
//     Non-contiguous masks are still compacted in slot order.
//   - out_valid[0] = (count>=1) && !flush; out_valid[1] = (count>=2) && !flush.
//     Lane0 shows entry[head]; lane1 shows entry[head+1] (modulo DEPTH).
//   - Dequeue in order: pop0 = out_valid[0]&out_ready[0];
//     pop1 = pop0 & out_valid[1] & out_ready[1].
//     out_ready[1] without out_ready[0] pops nothing. n_deq = pop0+pop1.
//   - Each edge without flush: head += n_deq; tail += n_enq; count += n_enq - n_deq.
//     Simultaneous enqueue and dequeue is legal, including on wrap.
//   - flush=1 (synchronous, highest priority after reset): next edge head=tail=count=0.
//     The same-cycle enqueue and dequeue are discarded. out_valid and in_ready are
//     forced 0 combinationally during the flush cycle.
//   - Overflow cannot occur (in_ready guard). Underflow cannot occur (out_valid guard).
//   - Latency: a group enqueued at edge N is visible on lane0 in cycle N+1 (no bypass).
//   - Outputs are combinational from registered state plus flush; no comb path from
//     in_* to out_*.
// TESTING
//   1 reset; enqueue in_pc=0x1C000000, mask=1111, inst=A,B,C,D
//     -> next cycle count=4, out_valid=11, pc0=0x1C000000/A, pc1=0x1C000004/B;
//        out_ready=11 -> then C,D.
//   2 in_pc=0x1C000014, mask=1110, jump=0100, target=0x1C000100
//     -> 3 entries, pc 0x1C000014/18/1C;
//        only pc 0x1C000018 has out_jump=1, tgt=0x1C000100.
//   3 fill to count=13
//     -> in_ready=0; with out_ready=11 the same cycle in_ready stays 0;
//        next cycle count=11, in_ready=1.
//   4 stream 40 random-mask groups with random out_ready for 200 cycles
//     -> scoreboard PC/inst order exact across head/tail wrap; count never > DEPTH.
//   5 count=10 plus in_valid and out_ready=11 with flush=1
//     -> out_valid=00 that cycle; next cycle count=0, the group is dropped,
//        in_ready=1.
//   6 assert reset between clock edges with count=7
//     -> count=0, out_valid=00 before the next edge; out_ready=10 case pops nothing.

Source files
------------

// File: rtl/fetch_inst_buffer.sv
// Instruction buffer between fetch and dual-issue decode.
// Each fetch group of up to four slots is compacted in slot order into a
// circular FIFO. The two oldest entries are presented to decode on lane0/lane1.
// Outputs come only from registered state and flush, so no path runs from in_* to out_*.
module fetch_inst_buffer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [127:0]     in_inst,
  input  logic [3:0]       in_mask,
  input  logic [3:0]       in_jump,
  input  logic [31:0]      in_target,
  output logic [1:0]       out_valid,
  input  logic [1:0]       out_ready,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst0,
  output logic [31:0]      out_inst1,
  output logic             out_jump0,
  output logic             out_jump1,
  output logic [31:0]      out_tgt0,
  output logic [31:0]      out_tgt1,
  output logic [IDX_W:0]   count
);

  // A full group needs four free entries, so the highest occupancy that can accept one is DEPTH-4.
  localparam logic [IDX_W:0] FILL_LIMIT = (IDX_W+1)'(DEPTH - 4);
  localparam logic [IDX_W:0] CNT_TWO    = (IDX_W+1)'(2);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic             jump_mem [DEPTH];
  logic [31:0]      tgt_mem  [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W-1:0] head_p1;

  logic [31:0]      grp_base;
  logic             enq_fire;
  logic [2:0]       n_mask;
  logic [2:0]       n_enq;
  logic [IDX_W-1:0] slot_off [4];
  logic             pop0;
  logic             pop1;
  logic [1:0]       n_deq;

  // The low PC bits only select a slot within the group; the group base discards them.
  logic             pc_offset_unused;
  assign pc_offset_unused = ^in_pc[3:0];

  assign grp_base = {in_pc[31:4], 4'b0000};
  assign head_p1  = head + IDX_W'(1);

  // The ready signal looks at the current occupancy only. A dequeue in the same cycle does not raise it.
  assign in_ready = (count <= FILL_LIMIT) && !flush;
  assign enq_fire = in_valid && in_ready;

  assign out_valid[0] = (count != '0) && !flush;
  assign out_valid[1] = (count >= CNT_TWO) && !flush;

  assign pop0  = out_valid[0] && out_ready[0];
  assign pop1  = pop0 && out_valid[1] && out_ready[1];
  assign n_deq = {1'b0, pop0} + {1'b0, pop1};

  // Slot k is written at tail plus the number of valid slots below it, which compacts holes in the mask.
  always_comb begin
    n_mask = 3'd0;
    for (int k = 0; k < 4; k++) begin
      slot_off[k] = IDX_W'(n_mask);
      n_mask      = n_mask + {2'b00, in_mask[k]};
    end
  end

  assign n_enq = enq_fire ? n_mask : 3'd0;

  assign out_pc0   = pc_mem[head];
  assign out_inst0 = inst_mem[head];
  assign out_jump0 = jump_mem[head];
  assign out_tgt0  = tgt_mem[head];
  assign out_pc1   = pc_mem[head_p1];
  assign out_inst1 = inst_mem[head_p1];
  assign out_jump1 = jump_mem[head_p1];
  assign out_tgt1  = tgt_mem[head_p1];

  // Pointer and occupancy update. Flush empties the buffer and drops the same-cycle enqueue and dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + IDX_W'(n_deq);
      tail  <= tail + IDX_W'(n_enq);
      count <= count + (IDX_W+1)'(n_enq) - (IDX_W+1)'(n_deq);
    end
  end

  // Entry storage is deliberately not reset. Only the slots that the mask selects are written.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int k = 0; k < 4; k++) begin
        if (in_mask[k]) begin
          pc_mem[tail + slot_off[k]]   <= grp_base + 32'(4 * k);
          inst_mem[tail + slot_off[k]] <= in_inst[32*k +: 32];
          jump_mem[tail + slot_off[k]] <= in_jump[k];
          tgt_mem[tail + slot_off[k]]  <= in_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Bench for fetch_inst_buffer: directed scenarios followed by a randomized stream
// checked against a queue-based reference model.
module tb_fetch_inst_buffer;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_pc = '0;
  logic [127:0] in_inst = '0;
  logic [3:0]   in_mask = '0;
  logic [3:0]   in_jump = '0;
  logic [31:0]  in_target = '0;
  logic [1:0]   out_valid;
  logic [1:0]   out_ready = 2'b00;
  logic [31:0]  out_pc0, out_pc1, out_inst0, out_inst1, out_tgt0, out_tgt1;
  logic         out_jump0, out_jump1;
  logic [IDX_W:0] count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        jump;
    logic [31:0] tgt;
  } ent_t;

  ent_t mq[$];

  fetch_inst_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_mask(in_mask), .in_jump(in_jump), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_jump0(out_jump0), .out_jump1(out_jump1), .out_tgt0(out_tgt0), .out_tgt1(out_tgt1),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Inputs change on the falling edge. Outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [127:0] inst,
                       input logic [3:0] mask, input logic [3:0] jump, input logic [31:0] tgt,
                       input logic [1:0] ordy, input logic fl);
    @(negedge clk);
    in_valid = v; in_pc = pc; in_inst = inst; in_mask = mask; in_jump = jump;
    in_target = tgt; out_ready = ordy; flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 128'h0, 4'h0, 4'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, count} !== {2'b00, 5'd0}) begin
      errors++; $display("FAIL reset_active: got ov/cnt %b/%0d want 00/0", out_valid, count);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, count} !== {1'b1, 2'b00, 5'd0}) begin
      errors++; $display("FAIL reset_release: got rdy/ov/cnt %b/%b/%0d want 1/00/0", in_ready, out_valid, count);
    end
  endtask

  task automatic test_full_group();
    drive(1'b1, 32'h1C000000, {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000},
          4'b1111, 4'b0000, 32'h0, 2'b00, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL t1_ready: got %b want 1", in_ready);
    end
    idle();
    checks++;
    if ({out_valid, count} !== {2'b11, 5'd4}) begin
      errors++; $display("FAIL t1_count: got ov/cnt %b/%0d want 11/4", out_valid, count);
    end
    checks++;
    if ({out_pc0, out_inst0, out_pc1, out_inst1} !== {32'h1C000000, 32'hAAAA0000, 32'h1C000004, 32'hBBBB0001}) begin
      errors++; $display("FAIL t1_lanes_ab: got %h %h %h %h", out_pc0, out_inst0, out_pc1, out_inst1);
    end
    drive(1'b0, 32'h0, 128'h0, 4'h0, 4'h0, 32'h0, 2'b11, 1'b0);
    drive(1'b0, 32'h0, 128'h0, 4'h0, 4'h0, 32'h0, 2'b11, 1'b0);
    checks++;
    if ({count, out_pc0, out_inst0, out_pc1, out_inst1} !== {5'd2, 32'h1C000008, 32'hCCCC0002, 32'h1C00000C, 32'hDDDD0003}) begin
      errors++; $display("FAIL t1_lanes_cd: got cnt %0d %h %h %h %h", count, out_pc0, out_inst0, out_pc1, out_inst1);
    end
    idle();
    checks++;
    if ({out_valid, count} !== {2'b00, 5'd0}) begin
      errors++; $display("FAIL t1_empty: got ov/cnt %b/%0d want 00/0", out_valid, count);
    end
  endtask

  task automatic test_partial_jump();
    drive(1'b1, 32'h1C000014, {32'h33330003, 32'h22220002, 32'h11110001, 32'h00000000},
          4'b1110, 4'b0100, 32'h1C000100, 2'b00, 1'b0);
    idle();
    checks++;
    if ({out_valid, count} !== {2'b11, 5'd3}) begin
      errors++; $display("FAIL t2_count: got ov/cnt %b/%0d want 11/3", out_valid, count);
    end
    checks++;
    if ({out_pc0, out_inst0, out_jump0, out_pc1, out_inst1, out_jump1, out_tgt1} !==
        {32'h1C000014, 32'h11110001, 1'b0, 32'h1C000018, 32'h22220002, 1'b1, 32'h1C000100}) begin
      errors++; $display("FAIL t2_lanes: got %h %h j%b %h %h j%b %h", out_pc0, out_inst0, out_jump0, out_pc1, out_inst1, out_jump1, out_tgt1);
    end
    drive(1'b0, 32'h0, 128'h0, 4'h0, 4'h0, 32'h0, 2'b01, 1'b0);
    idle();
    checks++;
    if ({count, out_pc0, out_jump0, out_tgt0, out_pc1, out_inst1, out_jump1} !==
        {5'd2, 32'h1C000018, 1'b1, 32'h1C000100, 32'h1C00001C, 32'h33330003, 1'b0}) begin
      errors++; $display("FAIL t2_single_pop: got cnt %0d %h j%b %h %h %h j%b", count, out_pc0, out_jump0, out_tgt0, out_pc1, out_inst1, out_jump1);
    end
    drive(1'b0, 32'h0, 128'h0, 4'h0, 4'h0, 32'h0, 2'b11, 1'b0);
    idle();
  endtask

  task automatic test_fill_limit();
    int n;
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h10000000 + 32'(16 * i), {$urandom, $urandom, $urandom, $urandom}, 4'b1111, 4'h0, 32'h0, 2'b00, 1'b0);
    drive(1'b1, 32'h10000030, {$urandom, $urandom, $urandom, $urandom}, 4'b0001, 4'h0, 32'h0, 2'b00, 1'b0);
    checks++;
    if ({in_ready, count} !== {1'b1, 5'd12}) begin
      errors++; $display("FAIL t3_at12: got rdy/cnt %b/%0d want 1/12", in_ready, count);
    end
    drive(1'b1, 32'h10000040, {$urandom, $urandom, $urandom, $urandom}, 4'b1111, 4'h0, 32'h0, 2'b11, 1'b0);
    checks++;
    if ({in_ready, out_valid, count} !== {1'b0, 2'b11, 5'd13}) begin
      errors++; $display("FAIL t3_at13: got rdy/ov/cnt %b/%b/%0d want 0/11/13", in_ready, out_valid, count);
    end
    idle();
    checks++;
    if ({in_ready, count, out_pc0} !== {1'b1, 5'd11, 32'h10000008}) begin
      errors++; $display("FAIL t3_after_pop: got rdy/cnt/pc0 %b/%0d/%h want 1/11/10000008", in_ready, count, out_pc0);
    end
    n = 0;
    while (count != 0 && n < 20) begin
      drive(1'b0, 32'h0, 128'h0, 4'h0, 4'h0, 32'h0, 2'b11, 1'b0);
      n++;
    end
    idle();
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL t3_drain: got cnt %0d want 0 within 20 cycles", count);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h20000000, {$urandom, $urandom, $urandom, $urandom}, 4'b1111, 4'h0, 32'h0, 2'b00, 1'b0);
    drive(1'b1, 32'h20000010, {$urandom, $urandom, $urandom, $urandom}, 4'b1111, 4'h0, 32'h0, 2'b00, 1'b0);
    drive(1'b1, 32'h20000020, {$urandom, $urandom, $urandom, $urandom}, 4'b0011, 4'h0, 32'h0, 2'b00, 1'b0);
    drive(1'b1, 32'h20000030, {$urandom, $urandom, $urandom, $urandom}, 4'b1111, 4'h0, 32'h0, 2'b11, 1'b1);
    checks++;
    if ({in_ready, out_valid, count} !== {1'b0, 2'b00, 5'd10}) begin
      errors++; $display("FAIL t5_flush_cycle: got rdy/ov/cnt %b/%b/%0d want 0/00/10", in_ready, out_valid, count);
    end
    idle();
    checks++;
    if ({in_ready, out_valid, count} !== {1'b1, 2'b00, 5'd0}) begin
      errors++; $display("FAIL t5_after_flush: got rdy/ov/cnt %b/%b/%0d want 1/00/0", in_ready, out_valid, count);
    end
    drive(1'b1, 32'h20000044, {32'h0, 32'h0, 32'h5EED0001, 32'h0}, 4'b0010, 4'h0, 32'h0, 2'b00, 1'b0);
    idle();
    checks++;
    if ({count, out_valid, out_pc0, out_inst0} !== {5'd1, 2'b01, 32'h20000044, 32'h5EED0001}) begin
      errors++; $display("FAIL t5_refill: got cnt/ov %0d/%b pc0 %h inst0 %h", count, out_valid, out_pc0, out_inst0);
    end
    drive(1'b0, 32'h0, 128'h0, 4'h0, 4'h0, 32'h0, 2'b01, 1'b0);
    idle();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h30000000, {$urandom, $urandom, $urandom, $urandom}, 4'b1111, 4'h0, 32'h0, 2'b00, 1'b0);
    drive(1'b1, 32'h30000010, {$urandom, $urandom, $urandom, $urandom}, 4'b0111, 4'h0, 32'h0, 2'b00, 1'b0);
    drive(1'b0, 32'h0, 128'h0, 4'h0, 4'h0, 32'h0, 2'b10, 1'b0);
    checks++;
    if ({out_valid, count} !== {2'b11, 5'd7}) begin
      errors++; $display("FAIL t6_before: got ov/cnt %b/%0d want 11/7", out_valid, count);
    end
    idle();
    checks++;
    if ({count, out_pc0} !== {5'd7, 32'h30000000}) begin
      errors++; $display("FAIL t6_lane1_only: got cnt/pc0 %0d/%h want 7/30000000", count, out_pc0);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, count} !== {2'b00, 5'd0}) begin
      errors++; $display("FAIL t6_async: got ov/cnt %b/%0d want 00/0", out_valid, count);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, count} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL t6_release: got rdy/cnt %b/%0d want 1/0", in_ready, count);
    end
  endtask

  task automatic test_back_to_back();
    int groups;
    groups = 0;
    mq.delete();
    for (int cyc = 0; cyc < 240; cyc++) begin
      logic         v;
      logic [31:0]  pc, tgt;
      logic [127:0] inst;
      logic [3:0]   mask, jump;
      logic [1:0]   ordy, exp_ov;
      logic         exp_ready;
      int           j, n_deq;
      ent_t         e;
      v    = (cyc < 200) && (groups < 40) && ($urandom_range(0, 3) != 0);
      pc   = $urandom;
      inst = {$urandom, $urandom, $urandom, $urandom};
      mask = 4'($urandom);
      j    = $urandom_range(0, 4);
      jump = 4'b0000;
      if (j < 4) jump[j] = 1'b1;
      tgt  = $urandom;
      ordy = (cyc < 200) ? 2'($urandom) : 2'b11;
      drive(v, pc, inst, mask, jump, tgt, ordy, 1'b0);

      exp_ready = (mq.size() <= DEPTH - 4);
      exp_ov    = {mq.size() >= 2, mq.size() >= 1};
      checks++;
      if ({in_ready, out_valid, count} !== {exp_ready, exp_ov, 5'(mq.size())}) begin
        errors++; $display("FAIL t4_status cyc %0d: got rdy/ov/cnt %b/%b/%0d want %b/%b/%0d", cyc, in_ready, out_valid, count, exp_ready, exp_ov, mq.size());
      end
      if (mq.size() >= 1) begin
        checks++;
        if ({out_pc0, out_inst0, out_jump0, (mq[0].jump ? out_tgt0 : 32'h0)} !==
            {mq[0].pc, mq[0].inst, mq[0].jump, (mq[0].jump ? mq[0].tgt : 32'h0)}) begin
          errors++; $display("FAIL t4_lane0 cyc %0d: got %h %h j%b want %h %h j%b", cyc, out_pc0, out_inst0, out_jump0, mq[0].pc, mq[0].inst, mq[0].jump);
        end
      end
      if (mq.size() >= 2) begin
        checks++;
        if ({out_pc1, out_inst1, out_jump1, (mq[1].jump ? out_tgt1 : 32'h0)} !==
            {mq[1].pc, mq[1].inst, mq[1].jump, (mq[1].jump ? mq[1].tgt : 32'h0)}) begin
          errors++; $display("FAIL t4_lane1 cyc %0d: got %h %h j%b want %h %h j%b", cyc, out_pc1, out_inst1, out_jump1, mq[1].pc, mq[1].inst, mq[1].jump);
        end
      end

      n_deq = 0;
      if (exp_ov[0] && ordy[0]) begin
        n_deq = 1;
        if (exp_ov[1] && ordy[1]) n_deq = 2;
      end
      for (int i = 0; i < n_deq; i++) void'(mq.pop_front());
      if (v && exp_ready) begin
        groups++;
        for (int k = 0; k < 4; k++) begin
          if (mask[k]) begin
            e.pc   = {pc[31:4], 4'b0000} + 32'(4 * k);
            e.inst = inst[32*k +: 32];
            e.jump = jump[k];
            e.tgt  = tgt;
            mq.push_back(e);
          end
        end
      end
    end
    idle();
    checks++;
    if ({count, out_valid} !== {5'(mq.size()), 2'b00}) begin
      errors++; $display("FAIL t4_drained: got cnt/ov %0d/%b want %0d/00", count, out_valid, mq.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_partial_jump();
    test_fill_limit();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
